// File: rtl/mult_sweep_monitor.sv
// mult_sweep_monitor
//   Sweeps every signed WIDTH x WIDTH operand pair into an exact and an approximate multiplier
//   and accumulates error statistics over the returned products. The host derives
//   NMED = (err_sum / count) / max_exact from the outputs.
//
//   Parameters
//     WIDTH     operand width; products are 2*WIDTH bits, sweep length N = 2**(2*WIDTH)
//     MULT_LAT  cycles from o_a/o_b to valid i_z_*; 0 = combinational multipliers
//     ACC_W     width of the saturating o_err_sum accumulator
//
//   Ports
//     i_clk, i_rst      clock (rising edge), asynchronous active-high reset
//     i_start           start a sweep; only accepted in IDLE or DONE
//     o_a, o_b          operands to both multipliers ({o_a,o_b} is the pair counter)
//     i_z_exact         exact product (signed)
//     i_z_approx        approximate product (signed)
//     o_busy, o_done    busy in SWEEP/DRAIN; done held in DONE
//     o_err_sum         saturating sum of |approx - exact|
//     o_max_exact       largest exact product seen, floor 0
//     o_count           pairs captured
//     o_err_cnt         pairs with a nonzero difference
//     o_max_err         largest |approx - exact| (only when ERR_MAX_EN is defined)
//
//   Build option: define ERR_MAX_EN to add the o_max_err port and its tracking logic.
module mult_sweep_monitor #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MULT_LAT = 0,
   parameter int unsigned ACC_W    = 40
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_start,
   output logic [WIDTH-1:0]     o_a,
   output logic [WIDTH-1:0]     o_b,
   input  logic [2*WIDTH-1:0]   i_z_exact,
   input  logic [2*WIDTH-1:0]   i_z_approx,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [ACC_W-1:0]     o_err_sum,
   output logic [2*WIDTH-1:0]   o_max_exact,
   output logic [2*WIDTH:0]     o_count,
   output logic [2*WIDTH:0]     o_err_cnt
`ifdef ERR_MAX_EN
   ,
   output logic [2*WIDTH:0]     o_max_err
`endif
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned DW = PW + 1;
   // Wide enough to hold the accumulator plus one magnitude without losing the carry.
   localparam int unsigned SW = ((ACC_W > DW) ? ACC_W : DW) + 1;
   localparam int unsigned LW = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;

   typedef enum logic [1:0] {StIdle, StSweep, StDrain, StDone} state_e;

   state_e           state_q, state_d;
   logic [PW-1:0]    pair_q, pair_d;
   logic [LW-1:0]    drain_q, drain_d;

   logic             start_acc;
   logic             issue;
   logic             cap_vld;

   logic [ACC_W-1:0] err_sum_q, err_sum_d;
   logic [PW-1:0]    max_exact_q, max_exact_d;
   logic [DW-1:0]    count_q, count_d;
   logic [DW-1:0]    err_cnt_q, err_cnt_d;

   logic [DW-1:0]    diff;
   logic [DW-1:0]    mag;
   logic [SW-1:0]    sum_wide;

   assign start_acc = i_start && ((state_q == StIdle) || (state_q == StDone));
   assign issue     = (state_q == StSweep);

   // ---------------------------------------------------------------------------------------
   // Control FSM and pair counter
   // ---------------------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      pair_d  = pair_q;
      drain_d = drain_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (i_start) begin
               state_d = StSweep;
               pair_d  = '0;
            end
         end
         StSweep: begin
            if (&pair_q) begin
               // Counter holds on the last pair so the operands stop toggling.
               state_d = (MULT_LAT == 0) ? StDone : StDrain;
               drain_d = '0;
            end else begin
               pair_d = pair_q + PW'(1);
            end
         end
         StDrain: begin
            if (drain_q == LW'(MULT_LAT - 1)) begin
               state_d = StDone;
            end else begin
               drain_d = drain_q + LW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= StIdle;
         pair_q  <= '0;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         pair_q  <= pair_d;
         drain_q <= drain_d;
      end
   end

   // ---------------------------------------------------------------------------------------
   // Tag pipe: tracks which cycles carry a valid product back from the multipliers
   // ---------------------------------------------------------------------------------------
   if (MULT_LAT == 0) begin : g_no_pipe
      assign cap_vld = issue;
   end else begin : g_pipe
      logic [MULT_LAT-1:0] tag_q;

      always_ff @(posedge i_clk or posedge i_rst) begin
         if (i_rst) begin
            tag_q <= '0;
         end else if (start_acc) begin
            tag_q <= '0;
         end else begin
            tag_q[0] <= issue;
            for (int i = 1; i < int'(MULT_LAT); i++) begin
               tag_q[i] <= tag_q[i-1];
            end
         end
      end

      assign cap_vld = tag_q[MULT_LAT-1];
   end

   // ---------------------------------------------------------------------------------------
   // Capture arithmetic
   // ---------------------------------------------------------------------------------------
   always_comb begin
      // One extra bit so the full exact/approx range difference cannot overflow.
      diff     = {i_z_approx[PW-1], i_z_approx} - {i_z_exact[PW-1], i_z_exact};
      mag      = diff[DW-1] ? (~diff + DW'(1)) : diff;
      sum_wide = SW'(err_sum_q) + SW'(mag);

      err_sum_d   = (|sum_wide[SW-1:ACC_W]) ? '1 : sum_wide[ACC_W-1:0];
      max_exact_d = ($signed(i_z_exact) > $signed(max_exact_q)) ? i_z_exact : max_exact_q;
      count_d     = count_q + DW'(1);
      err_cnt_d   = err_cnt_q + {{(DW-1){1'b0}}, |diff};
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         err_sum_q   <= '0;
         max_exact_q <= '0;
         count_q     <= '0;
         err_cnt_q   <= '0;
      end else if (start_acc) begin
         err_sum_q   <= '0;
         max_exact_q <= '0;
         count_q     <= '0;
         err_cnt_q   <= '0;
      end else if (cap_vld) begin
         err_sum_q   <= err_sum_d;
         max_exact_q <= max_exact_d;
         count_q     <= count_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

`ifdef ERR_MAX_EN
   logic [DW-1:0] max_err_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         max_err_q <= '0;
      end else if (start_acc) begin
         max_err_q <= '0;
      end else if (cap_vld && (mag > max_err_q)) begin
         max_err_q <= mag;
      end
   end

   assign o_max_err = max_err_q;
`endif

   // ---------------------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------------------
   assign o_a         = pair_q[PW-1:WIDTH];
   assign o_b         = pair_q[WIDTH-1:0];
   assign o_busy      = (state_q == StSweep) || (state_q == StDrain);
   assign o_done      = (state_q == StDone);
   assign o_err_sum   = err_sum_q;
   assign o_max_exact = max_exact_q;
   assign o_count     = count_q;
   assign o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_mult_sweep_monitor.sv
// Bench for mult_sweep_monitor. Two instances with WIDTH=4 (256 pairs per sweep):
//   u_dut0: MULT_LAT=0, ACC_W=40, combinational multiplier model
//   u_dut3: MULT_LAT=3, ACC_W=9,  three-stage registered multiplier model (saturates at 511)
// mode selects how the approximate (and for mode 3, the exact) product is formed:
//   0 approx = exact          1 approx = exact + 1       2 approx = exact with LSB cleared
//   3 exact = -128, approx = 127 (largest difference)    4 approx = exact + 3
module tb_mult_sweep_monitor;

   localparam int unsigned W  = 4;
   localparam int unsigned PW = 2 * W;

   logic clk = 1'b0;
   logic rst;
   logic start0, start3;
   int   mode;

   always #5 clk = ~clk;

   logic [W-1:0]  a0, b0, a3, b3;
   logic [PW-1:0] ex0, ap0, ex3, ap3;
   logic [PW-1:0] p1, p2, p3;

   logic          busy0, done0, busy3, done3;
   logic [39:0]   err_sum0;
   logic [8:0]    err_sum3;
   logic [PW-1:0] max_ex0, max_ex3;
   logic [PW:0]   count0, err_cnt0, count3, err_cnt3;
`ifdef ERR_MAX_EN
   logic [PW:0]   max_err0, max_err3;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [PW-1:0] prod(input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [PW-1:0] sa, sb;
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      return sa * sb;
   endfunction

   function automatic logic [PW-1:0] ex_sel(input int m, input logic [PW-1:0] p);
      return (m == 3) ? 8'h80 : p;
   endfunction

   function automatic logic [PW-1:0] ap_sel(input int m, input logic [PW-1:0] e);
      case (m)
         1:       return e + 8'd1;
         2:       return e & 8'hFE;
         3:       return 8'h7F;
         4:       return e + 8'd3;
         default: return e;
      endcase
   endfunction

   always_comb begin
      ex0 = ex_sel(mode, prod(a0, b0));
      ap0 = ap_sel(mode, ex0);
      ex3 = ex_sel(mode, p3);
      ap3 = ap_sel(mode, ex3);
   end

   always_ff @(posedge clk) begin
      p1 <= prod(a3, b3);
      p2 <= p1;
      p3 <= p2;
   end

   mult_sweep_monitor #(.WIDTH(W), .MULT_LAT(0), .ACC_W(40)) u_dut0 (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start0),
      .o_a         (a0),
      .o_b         (b0),
      .i_z_exact   (ex0),
      .i_z_approx  (ap0),
      .o_busy      (busy0),
      .o_done      (done0),
      .o_err_sum   (err_sum0),
      .o_max_exact (max_ex0),
      .o_count     (count0),
      .o_err_cnt   (err_cnt0)
`ifdef ERR_MAX_EN
      ,
      .o_max_err   (max_err0)
`endif
   );

   mult_sweep_monitor #(.WIDTH(W), .MULT_LAT(3), .ACC_W(9)) u_dut3 (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_start     (start3),
      .o_a         (a3),
      .o_b         (b3),
      .i_z_exact   (ex3),
      .i_z_approx  (ap3),
      .o_busy      (busy3),
      .o_done      (done3),
      .o_err_sum   (err_sum3),
      .o_max_exact (max_ex3),
      .o_count     (count3),
      .o_err_cnt   (err_cnt3)
`ifdef ERR_MAX_EN
      ,
      .o_max_err   (max_err3)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Starts both instances and watches them for a fixed 400-cycle window. Cycle 1 is the
   // first cycle after the edge that samples the start pulse.
   task automatic run_sweep(input string t, input bit inject);
      int done0_cyc = 0;
      int done3_cyc = 0;
      int busy0_n   = 0;
      int busy3_n   = 0;
      @(negedge clk);
      start0 = 1'b1;
      start3 = 1'b1;
      @(posedge clk);
      #1;
      start0 = 1'b0;
      start3 = 1'b0;
      for (int cyc = 1; cyc <= 400; cyc++) begin
         if (cyc == 1) begin
            check({t, " a0 first"}, 64'(a0), 64'd0);
            check({t, " b0 first"}, 64'(b0), 64'd0);
            check({t, " b3 first"}, 64'(b3), 64'd0);
         end
         if (cyc == 2) check({t, " b0 second"}, 64'(b0), 64'd1);
         if (busy0) busy0_n++;
         if (busy3) busy3_n++;
         if (done0 && done0_cyc == 0) done0_cyc = cyc;
         if (done3 && done3_cyc == 0) done3_cyc = cyc;
         // Extra pulses land in SWEEP (cycle 50) and, for u_dut3, in DRAIN (cycle 258).
         start0 = inject && (cyc == 50);
         start3 = inject && ((cyc == 50) || (cyc == 258));
         @(posedge clk);
         #1;
      end
      start0 = 1'b0;
      start3 = 1'b0;
      check({t, " done0 cycle"}, 64'(done0_cyc), 64'd257);
      check({t, " done3 cycle"}, 64'(done3_cyc), 64'd260);
      check({t, " busy0 cycles"}, 64'(busy0_n), 64'd256);
      check({t, " busy3 cycles"}, 64'(busy3_n), 64'd259);
      check({t, " a0 held"}, 64'(a0), 64'hF);
      check({t, " b3 held"}, 64'(b3), 64'hF);
   endtask

   task automatic check_results(input string t, input longint s0, input longint s3,
                                input longint ec, input longint mx, input longint me);
      check({t, " err_sum0"},  64'(err_sum0), 64'(s0));
      check({t, " err_sum3"},  64'(err_sum3), 64'(s3));
      check({t, " count0"},    64'(count0),   64'd256);
      check({t, " count3"},    64'(count3),   64'd256);
      check({t, " err_cnt0"},  64'(err_cnt0), 64'(ec));
      check({t, " err_cnt3"},  64'(err_cnt3), 64'(ec));
      check({t, " max_ex0"},   64'(max_ex0),  64'(mx));
      check({t, " max_ex3"},   64'(max_ex3),  64'(mx));
`ifdef ERR_MAX_EN
      check({t, " max_err0"},  64'(max_err0), 64'(me));
      check({t, " max_err3"},  64'(max_err3), 64'(me));
`else
      if (me < 0) $display("unexpected negative max_err %0d", me);
`endif
   endtask

   initial begin
      rst    = 1'b1;
      start0 = 1'b0;
      start3 = 1'b0;
      mode   = 0;
      repeat (3) @(posedge clk);
      #1;
      check("rst busy0",    64'(busy0),    64'd0);
      check("rst done0",    64'(done0),    64'd0);
      check("rst err_sum0", 64'(err_sum0), 64'd0);
      check("rst count0",   64'(count0),   64'd0);
      check("rst max_ex0",  64'(max_ex0),  64'd0);
      check("rst a0",       64'(a0),       64'd0);
      check("rst busy3",    64'(busy3),    64'd0);
      check("rst count3",   64'(count3),   64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      mode = 0; run_sweep("m0", 1'b0); check_results("m0", 0, 0, 0, 64, 0);
      mode = 1; run_sweep("m1", 1'b0); check_results("m1", 256, 256, 256, 64, 1);
      mode = 2; run_sweep("m2", 1'b0); check_results("m2", 64, 64, 64, 64, 1);
      mode = 3; run_sweep("m3", 1'b0); check_results("m3", 65280, 511, 256, 0, 255);
      mode = 4; run_sweep("m4", 1'b0); check_results("m4", 768, 511, 256, 64, 3);

      // Reset in the middle of a sweep.
      mode = 1;
      @(negedge clk);
      start0 = 1'b1;
      start3 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      start3 = 1'b0;
      repeat (100) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid-rst busy0",    64'(busy0),    64'd0);
      check("mid-rst done0",    64'(done0),    64'd0);
      check("mid-rst err_sum0", 64'(err_sum0), 64'd0);
      check("mid-rst count0",   64'(count0),   64'd0);
      check("mid-rst a0",       64'(a0),       64'd0);
      check("mid-rst b0",       64'(b0),       64'd0);
      check("mid-rst busy3",    64'(busy3),    64'd0);
      check("mid-rst count3",   64'(count3),   64'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("post-rst idle busy0", 64'(busy0), 64'd0);
      check("post-rst idle done3", 64'(done3), 64'd0);
      mode = 0; run_sweep("r0", 1'b0); check_results("r0", 0, 0, 0, 64, 0);

      // Start pulses during SWEEP and DRAIN are ignored; the run begins from DONE.
      mode = 1; run_sweep("ig", 1'b1); check_results("ig", 256, 256, 256, 64, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
